score_mem_reader: RTL and testbench

- Read-side counterpart of the feature-score writer: once a frame's scores are in score memory, this block scans every address in order.
- For each address it issues a read and tags the returned score with its address.
- Scores at or above a programmable minimum are buffered and streamed out as (address, score) corner records over a valid/ready handshake.
- It sits between score memory and the downstream corner consumer (corner list builder / host readout). Reads are pipelined at one per cycle, with a skid FIFO absorbing in-flight data under backpressure.

---
 rtl/score_mem_reader.sv | 150 +++++++++++++++
 tb/tb_score_mem_reader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_mem_reader.sv
// Scans score memory 0..DEPTH-1 and streams (addr, score) records at or above a threshold.
// Optional SCORE_CLEAR_EN: zero each address in score memory as its read data returns.
module score_mem_reader #(
  parameter int ADDR_W  = 15,
  parameter int SCORE_W = 8,
  parameter int DEPTH   = 32768,
  parameter int RD_LAT  = 2,
  parameter int FIFO_D  = 4
) (
  input  logic               clock,
  input  logic               nReset,
  input  logic               start,
  input  logic [SCORE_W-1:0] minScore,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  memAddr,
  input  logic [SCORE_W-1:0] memQ,
  output logic [ADDR_W-1:0]  memWrAddr,
  output logic [SCORE_W-1:0] memData,
  output logic               memWren,
  output logic               outValid,
  input  logic               outReady,
  output logic [ADDR_W-1:0]  outAddr,
  output logic [SCORE_W-1:0] outScore,
  output logic [15:0]        cornerCount
);

  localparam int CW = $clog2(FIFO_D + RD_LAT + 1);
  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [CW-1:0]   FIFO_C  = CW'(FIFO_D);
  localparam logic [PW-1:0]   PTR_MAX = PW'(FIFO_D - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [SCORE_W-1:0] score;
  } rec_t;

  state_t                         state, state_nxt;
  logic [ADDR_W:0]                issue_cnt;
  logic [SCORE_W-1:0]             thr;
  logic [RD_LAT-1:0]              vld_pipe;
  logic [RD_LAT-1:0][ADDR_W-1:0]  addr_pipe;
  rec_t                           fifo [FIFO_D];
  logic [PW-1:0]                  wr_ptr, rd_ptr;
  logic [CW-1:0]                  fifo_cnt, inflight;
  logic                           accept, issue, tail_vld, push, pop;
  logic [ADDR_W-1:0]              tail_addr;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld_pipe[i]);
  end

  assign tail_vld  = vld_pipe[RD_LAT-1];
  assign tail_addr = addr_pipe[RD_LAT-1];
  assign push      = tail_vld && (memQ >= thr);
  assign outValid  = (fifo_cnt != '0);
  assign pop       = outValid && outReady;
  assign outAddr   = fifo[rd_ptr].addr;
  assign outScore  = fifo[rd_ptr].score;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept    = 1'b1;
        state_nxt = SCAN;
      end
      // Counting the tail word as in flight keeps a push from ever meeting a full FIFO.
      SCAN: begin
        issue = (fifo_cnt + inflight < FIFO_C) && (issue_cnt < DEPTH_C);
        if (issue && issue_cnt == LAST) state_nxt = DRAIN;
      end
      DRAIN: if (inflight == '0 && fifo_cnt == '0) begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      issue_cnt   <= '0;
      thr         <= '0;
      cornerCount <= '0;
      memAddr     <= '0;
      vld_pipe    <= '0;
      addr_pipe   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        thr         <= (minScore == '0) ? SCORE_W'(1) : minScore;
        issue_cnt   <= '0;
        cornerCount <= '0;
      end else if (push && ~&cornerCount) begin
        cornerCount <= cornerCount + 1'b1;
      end
      if (issue) begin
        memAddr   <= issue_cnt[ADDR_W-1:0];
        issue_cnt <= issue_cnt + 1'b1;
      end
      vld_pipe[0]  <= issue;
      addr_pipe[0] <= issue_cnt[ADDR_W-1:0];
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < FIFO_D; i++) fifo[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo[wr_ptr] <= '{addr: tail_addr, score: memQ};
        wr_ptr       <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef SCORE_CLEAR_EN
  assign memWren   = tail_vld;
  assign memWrAddr = tail_addr;
  assign memData   = '0;
`else
  assign memWren   = 1'b0;
  assign memWrAddr = '0;
  assign memData   = '0;
`endif

endmodule

// File: tb/tb_score_mem_reader.sv
// Bench for score_mem_reader (DEPTH=16, RD_LAT=2, FIFO_D=4) with a registered-read memory model.
module tb_score_mem_reader;
  localparam int AW = 15, SW = 8, N = 16, RL = 2, FD = 4;

  logic clock = 1'b0, nReset = 1'b0, start = 1'b0, outReady = 1'b0;
  logic [SW-1:0] minScore = '0, memQ, memData, outScore;
  logic [AW-1:0] memAddr, memWrAddr, outAddr;
  logic busy, done, memWren, outValid;
  logic [15:0] cornerCount;

  always #5 clock = ~clock;

  score_mem_reader #(.ADDR_W(AW), .SCORE_W(SW), .DEPTH(N), .RD_LAT(RL), .FIFO_D(FD)) dut (
    .clock(clock), .nReset(nReset), .start(start), .minScore(minScore), .busy(busy), .done(done),
    .memAddr(memAddr), .memQ(memQ), .memWrAddr(memWrAddr), .memData(memData), .memWren(memWren),
    .outValid(outValid), .outReady(outReady), .outAddr(outAddr), .outScore(outScore),
    .cornerCount(cornerCount));

  logic [SW-1:0] mem [N], mem_init [N], model_mem [N];
  logic load = 1'b0;

  // Address registered by the DUT, data registered here: RD_LAT=2 overall.
  always @(posedge clock) begin
    memQ <= mem[memAddr[3:0]];
    if (load) for (int i = 0; i < N; i++) mem[i] <= mem_init[i];
    else if (memWren) mem[memWrAddr[3:0]] <= memData;
  end

  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, done_cyc = 0, wren_cnt = 0, wr_viol = 0;
  int hold_viol = 0, start_cyc = 0, beat_first = 0, beat_last = 0, stall_addr = 0;
  logic [AW+SW-1:0] got [$], expq [$], held;
  logic hold_pend = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!nReset) hold_pend = 1'b0;
    else begin
      if (outValid && outReady) begin
        if (got.size() == 0) beat_first = cyc;
        beat_last = cyc;
        got.push_back({outAddr, outScore});
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (memWren) wren_cnt++;
      if (memWrAddr != '0 || memData != '0) wr_viol++;
      if (hold_pend && !(outValid && {outAddr, outScore} == held)) hold_viol++;
      hold_pend = outValid && !outReady;
      held = {outAddr, outScore};
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic load_mem();
    for (int i = 0; i < N; i++) model_mem[i] = mem_init[i];
    load = 1'b1; step(); load = 1'b0;
  endtask

  // Reference: every address in order whose score reaches max(minScore,1).
  function automatic void build_exp(input logic [SW-1:0] ms);
    logic [SW-1:0] t;
    t = (ms == '0) ? SW'(1) : ms;
    expq.delete();
    for (int a = 0; a < N; a++) if (model_mem[a] >= t) expq.push_back({AW'(a), model_mem[a]});
  endfunction

  // mode 0: always ready, 1: random ready, 2: stalled for 20 cycles then ready.
  task automatic run_scan(input logic [SW-1:0] ms, input int mode, input int restart_at, output bit ok);
    got.delete(); hold_viol = 0; ok = 1'b0;
    minScore = ms; start = 1'b1; outReady = (mode != 2);
    step();
    start = 1'b0; start_cyc = cyc; minScore = SW'($urandom);
    for (int n = 0; n < 300; n++) begin
      case (mode)
        0: outReady = 1'b1;
        1: outReady = 1'($urandom_range(0, 1));
        default: outReady = (n >= 20);
      endcase
      start = (n == restart_at);
      if (n == 19) stall_addr = int'(memAddr);
      step();
      if (done_cnt != 0 && done_cyc > start_cyc) begin ok = 1'b1; break; end
    end
    start = 1'b0; outReady = 1'b1;
    repeat (3) step();
`ifdef SCORE_CLEAR_EN
    if (ok) for (int i = 0; i < N; i++) model_mem[i] = '0;
`endif
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, memWren, outValid} !== 4'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, memWren, outValid}); end
    checks++;
    if ({memAddr, memWrAddr, memData, outAddr, outScore, cornerCount} !== '0)
      begin errors++; $display("FAIL reset_data: got nonzero data outputs, want all 0"); end
    step(); step();
    nReset = 1'b1;
    step();
  endtask

  task automatic test_single_corner();
    bit ok; int d0;
    for (int i = 0; i < N; i++) mem_init[i] = '0;
    mem_init[3] = 8'd20; mem_init[15] = 8'd5;
    load_mem(); build_exp(8'd10); d0 = done_cnt;
    run_scan(8'd10, 0, -1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: done not seen"); end
    checks++; if (got.size() != 1 || got[0] !== {AW'(3), 8'd20})
      begin errors++; $display("FAIL single_beat: got %0d beats, want 1 beat addr 3 score 20", got.size()); end
    checks++; if (cornerCount !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", cornerCount); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done: got %0d pulses want 1", done_cnt - d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    for (int i = 0; i < N; i++) mem_init[i] = 8'd50;
    load_mem(); build_exp(8'd10);
    run_scan(8'd10, 2, -1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: done not seen"); end
    checks++; if (stall_addr != FD - 1) begin errors++; $display("FAIL bp_stall_addr: got %0d want %0d", stall_addr, FD - 1); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL bp_hold: got %0d violations want 0", hold_viol); end
    checks++; if (got.size() != expq.size()) begin errors++; $display("FAIL bp_len: got %0d want %0d", got.size(), expq.size()); end
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      checks++; if (got[i] !== expq[i]) begin errors++; $display("FAIL bp_beat%0d: got %h want %h", i, got[i], expq[i]); end
    end
    checks++; if (cornerCount !== 16'(expq.size())) begin errors++; $display("FAIL bp_count: got %0d want %0d", cornerCount, expq.size()); end
  endtask

  task automatic test_min_zero();
    bit ok;
    for (int i = 0; i < N; i++) mem_init[i] = '0;
    mem_init[1] = 8'd1; mem_init[3] = 8'd7;
    load_mem(); build_exp(8'd0);
    run_scan(8'd0, 0, -1, ok);
    checks++; if (!ok || got.size() != 2) begin errors++; $display("FAIL minzero_len: got %0d want 2", got.size()); end
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      checks++; if (got[i] !== expq[i]) begin errors++; $display("FAIL minzero_beat%0d: got %h want %h", i, got[i], expq[i]); end
    end
  endtask

  task automatic test_restart_ignored();
    bit ok; int d0; logic [SW-1:0] ms;
    for (int i = 0; i < N; i++) mem_init[i] = SW'($urandom_range(0, 100));
    ms = 8'd50;
    load_mem(); build_exp(ms); d0 = done_cnt;
    run_scan(ms, 1, 5, ok);
    checks++; if (!ok || done_cnt - d0 != 1) begin errors++; $display("FAIL restart_done: got %0d pulses want 1", done_cnt - d0); end
    checks++; if (got != expq) begin errors++; $display("FAIL restart_list: got %0d beats want %0d", got.size(), expq.size()); end
    checks++; if (cornerCount !== 16'(expq.size())) begin errors++; $display("FAIL restart_count: got %0d want %0d", cornerCount, expq.size()); end
  endtask

  task automatic test_abort();
    bit ok, seen; int d0;
    for (int i = 0; i < N; i++) mem_init[i] = 8'd40;
    load_mem(); build_exp(8'd40);
    minScore = 8'd40; start = 1'b1; outReady = 1'b1; step(); start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin step(); seen = (memAddr == AW'(7)); end
    checks++; if (!seen) begin errors++; $display("FAIL abort_reach: memAddr %0d never reached 7", memAddr); end
    d0 = done_cnt;
    nReset = 1'b0; #1;
    checks++;
    if ({busy, done, memWren, outValid, memAddr, memWrAddr, memData, outAddr, outScore, cornerCount} !== '0)
      begin errors++; $display("FAIL abort_outputs: got nonzero outputs during reset, want all 0"); end
    step(); step();
    nReset = 1'b1;
    repeat (25) step();
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_nodone: got %0d pulses want 0", done_cnt - d0); end
    run_scan(8'd40, 0, -1, ok);
    checks++; if (!ok || got != expq) begin errors++; $display("FAIL abort_rescan: got %0d beats want %0d", got.size(), expq.size()); end
  endtask

  task automatic test_clear();
    bit ok; int want_w;
`ifdef SCORE_CLEAR_EN
    want_w = N;
`else
    want_w = 0;
`endif
    for (int i = 0; i < N; i++) mem_init[i] = 8'd30;
    load_mem();
    for (int s = 0; s < 2; s++) begin
      build_exp(8'd1); wren_cnt = 0; wr_viol = 0;
      run_scan(8'd1, 0, -1, ok);
      checks++; if (!ok || cornerCount !== 16'(expq.size()))
        begin errors++; $display("FAIL clear_count%0d: got %0d want %0d", s, cornerCount, expq.size()); end
      checks++; if (wren_cnt != want_w) begin errors++; $display("FAIL clear_wren%0d: got %0d want %0d", s, wren_cnt, want_w); end
      checks++; if (wr_viol != 0) begin errors++; $display("FAIL clear_wdata%0d: got %0d nonzero cycles want 0", s, wr_viol); end
    end
  endtask

  task automatic test_throughput();
    bit ok;
    for (int i = 0; i < N; i++) mem_init[i] = 8'd255;
    load_mem(); build_exp(8'd255);
    run_scan(8'd255, 0, -1, ok);
    checks++; if (!ok || done_cyc - start_cyc > N + RL + 3)
      begin errors++; $display("FAIL tput_latency: got %0d cycles want <= %0d", done_cyc - start_cyc, N + RL + 3); end
    checks++; if (got != expq) begin errors++; $display("FAIL tput_list: got %0d beats want %0d", got.size(), expq.size()); end
    checks++; if (beat_last - beat_first != N - 1)
      begin errors++; $display("FAIL tput_consec: got span %0d want %0d", beat_last - beat_first, N - 1); end
  endtask

  task automatic test_random();
    bit ok; logic [SW-1:0] ms;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++)
        mem_init[i] = ($urandom_range(0, 2) == 0) ? SW'($urandom) : SW'($urandom_range(0, 3));
      ms = ($urandom_range(0, 3) == 0) ? 8'd0 : SW'($urandom_range(0, 200));
      load_mem(); build_exp(ms);
      run_scan(ms, 1, -1, ok);
      checks++; if (!ok || got != expq)
        begin errors++; $display("FAIL rand%0d_list: got %0d beats want %0d", it, got.size(), expq.size()); end
      checks++; if (cornerCount !== 16'(expq.size()))
        begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", it, cornerCount, expq.size()); end
      checks++; if (hold_viol != 0) begin errors++; $display("FAIL rand%0d_hold: got %0d want 0", it, hold_viol); end
    end
  endtask

  initial begin
    test_reset();
    test_single_corner();
    test_backpressure();
    test_min_zero();
    test_restart_ignored();
    test_abort();
    test_clear();
    test_throughput();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
